// File: rtl/estacionamiento_pkg.sv
// Shared definitions for the multi-lane parking counter: lane FSM state codes and sensor codes.
package estacionamiento_pkg;

    typedef logic [2:0] estado_t;

    localparam estado_t IDLE = 3'd0;
    localparam estado_t E_A  = 3'd1;
    localparam estado_t E_AB = 3'd2;
    localparam estado_t E_B  = 3'd3;
    localparam estado_t S_B  = 3'd4;
    localparam estado_t S_BA = 3'd5;
    localparam estado_t S_A  = 3'd6;

    // Sensor codes are {a, b}, 1 = beam blocked.
    localparam logic [1:0] COD_LIBRE = 2'b00;
    localparam logic [1:0] COD_A     = 2'b10;
    localparam logic [1:0] COD_B     = 2'b01;
    localparam logic [1:0] COD_AB    = 2'b11;

endpackage

// File: rtl/control_estacionamiento_n_fsm_carril.sv
// One lane's a/b sensor-sequence recogniser producing registered entry/exit pulses.
// ALARMA_SECUENCIA_EN adds a registered pulse on every invalid two-bit jump.
module fsm_carril
    import estacionamiento_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic entrada,
    output logic salida
`ifdef ALARMA_SECUENCIA_EN
    ,
    output logic invalido
`endif
);

    logic [1:0] codigo;
    estado_t    estado_q, estado_d;
    logic       entrada_q, entrada_d;
    logic       salida_q, salida_d;
    logic       invalido_d;

    assign codigo = {a, b};

    // Each state accepts hold, one step forward and one step back; anything else is invalid.
    always_comb begin
        estado_d   = estado_q;
        entrada_d  = 1'b0;
        salida_d   = 1'b0;
        invalido_d = 1'b0;
        case (estado_q)
            IDLE: case (codigo)
                COD_LIBRE: ;
                COD_A:     estado_d = E_A;
                COD_B:     estado_d = S_B;
                default:   invalido_d = 1'b1;
            endcase
            E_A: case (codigo)
                COD_A:     ;
                COD_AB:    estado_d = E_AB;
                COD_LIBRE: estado_d = IDLE;
                default:   invalido_d = 1'b1;
            endcase
            E_AB: case (codigo)
                COD_AB:    ;
                COD_B:     estado_d = E_B;
                COD_A:     estado_d = E_A;
                default:   invalido_d = 1'b1;
            endcase
            E_B: case (codigo)
                COD_B:     ;
                COD_LIBRE: begin
                    estado_d  = IDLE;
                    entrada_d = 1'b1;
                end
                COD_AB:    estado_d = E_AB;
                default:   invalido_d = 1'b1;
            endcase
            S_B: case (codigo)
                COD_B:     ;
                COD_AB:    estado_d = S_BA;
                COD_LIBRE: estado_d = IDLE;
                default:   invalido_d = 1'b1;
            endcase
            S_BA: case (codigo)
                COD_AB:    ;
                COD_A:     estado_d = S_A;
                COD_B:     estado_d = S_B;
                default:   invalido_d = 1'b1;
            endcase
            S_A: case (codigo)
                COD_A:     ;
                COD_LIBRE: begin
                    estado_d = IDLE;
                    salida_d = 1'b1;
                end
                COD_AB:    estado_d = S_BA;
                default:   invalido_d = 1'b1;
            endcase
            default: estado_d = IDLE;
        endcase
        if (invalido_d) estado_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= IDLE;
            entrada_q <= 1'b0;
            salida_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            entrada_q <= entrada_d;
            salida_q  <= salida_d;
        end
    end

    assign entrada = entrada_q;
    assign salida  = salida_q;

`ifdef ALARMA_SECUENCIA_EN
    logic invalido_q;

    always_ff @(posedge clk) begin
        if (rst) invalido_q <= 1'b0;
        else     invalido_q <= invalido_d;
    end

    assign invalido = invalido_q;
`endif

endmodule

// File: rtl/control_estacionamiento_n.sv
// N-lane parking occupancy counter with saturating shared count and blinking full indicator.
// ALARMA_SECUENCIA_EN adds sticky sequence-error outputs alarma / alarma_carril.
module control_estacionamiento_n
    import estacionamiento_pkg::*;
#(
    parameter int N_CARRILES   = 2,
    parameter int CAPACIDAD    = 7,
    parameter int CLK_FREQ     = 12000000,
    parameter int BLINK_CYCLES = CLK_FREQ * 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CARRILES-1:0]              a,
    input  logic [N_CARRILES-1:0]              b,
    output logic [$clog2(CAPACIDAD+1)-1:0]     ocupacion,
    output logic                               lleno,
    output logic                               vacio,
    output logic                               led_lleno,
    output logic                               rechazo
`ifdef ALARMA_SECUENCIA_EN
    ,
    output logic                               alarma,
    output logic [N_CARRILES-1:0]              alarma_carril
`endif
);

    localparam int W  = $clog2(CAPACIDAD + 1);
    localparam int NW = W + 4;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0]        BLINK_MAX = BW'(BLINK_CYCLES - 1);
    localparam logic signed [NW-1:0] CAP_S     = NW'(CAPACIDAD);

    logic [N_CARRILES-1:0] entrada, salida;
    logic signed [NW-1:0]  net, suma;
    logic [W-1:0]          ocup_q, ocup_d;
    logic                  rechazo_q, rechazo_d;
    logic [BW-1:0]         blink_q;
    logic                  led_q;

`ifdef ALARMA_SECUENCIA_EN
    logic [N_CARRILES-1:0] invalido;
    logic [N_CARRILES-1:0] alarma_q;
`endif

    for (genvar i = 0; i < N_CARRILES; i++) begin : g_carril
        fsm_carril u_fsm (
            .clk     (clk),
            .rst     (rst),
            .a       (a[i]),
            .b       (b[i]),
            .entrada (entrada[i]),
            .salida  (salida[i])
`ifdef ALARMA_SECUENCIA_EN
            ,
            .invalido(invalido[i])
`endif
        );
    end

    // Net change summed across all lanes, then clamped; a partial clamp still flags rechazo.
    always_comb begin
        net = '0;
        for (int i = 0; i < N_CARRILES; i++) begin
            net = net + $signed(NW'(entrada[i])) - $signed(NW'(salida[i]));
        end
        suma      = $signed({4'b0000, ocup_q}) + net;
        rechazo_d = 1'b0;
        if (suma < 0) begin
            ocup_d    = '0;
            rechazo_d = 1'b1;
        end else if (suma > CAP_S) begin
            ocup_d    = W'(CAPACIDAD);
            rechazo_d = 1'b1;
        end else begin
            ocup_d = suma[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocup_q    <= '0;
            rechazo_q <= 1'b0;
            blink_q   <= '0;
            led_q     <= 1'b0;
        end else begin
            ocup_q    <= ocup_d;
            rechazo_q <= rechazo_d;
            if (lleno) begin
                if (blink_q == BLINK_MAX) begin
                    blink_q <= '0;
                    led_q   <= ~led_q;
                end else begin
                    blink_q <= blink_q + 1'b1;
                end
            end else begin
                blink_q <= '0;
                led_q   <= 1'b0;
            end
        end
    end

    assign ocupacion = ocup_q;
    assign lleno     = (ocup_q == W'(CAPACIDAD));
    assign vacio     = (ocup_q == '0);
    // Masked so the indicator drops in the same cycle the lot stops being full.
    assign led_lleno = led_q & lleno;
    assign rechazo   = rechazo_q;

`ifdef ALARMA_SECUENCIA_EN
    always_ff @(posedge clk) begin
        if (rst) alarma_q <= '0;
        else     alarma_q <= alarma_q | invalido;
    end

    assign alarma_carril = alarma_q;
    assign alarma        = |alarma_q;
`endif

endmodule

// File: tb/tb_control_estacionamiento_n.sv
// Scoreboard bench for control_estacionamiento_n: directed plan then randomized lane traffic.
module tb_control_estacionamiento_n;

    localparam int NC    = 2;
    localparam int CAP   = 3;
    localparam int BLINK = 4;
    localparam int W     = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] a, b;
    logic [W-1:0]  ocupacion;
    logic          lleno, vacio, led_lleno, rechazo;
`ifdef ALARMA_SECUENCIA_EN
    logic          alarma;
    logic [NC-1:0] alarma_carril;
`endif

    always #5 clk = ~clk;

    control_estacionamiento_n #(
        .N_CARRILES  (NC),
        .CAPACIDAD   (CAP),
        .CLK_FREQ    (8),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .ocupacion    (ocupacion),
        .lleno        (lleno),
        .vacio        (vacio),
        .led_lleno    (led_lleno),
        .rechazo      (rechazo)
`ifdef ALARMA_SECUENCIA_EN
        ,
        .alarma       (alarma),
        .alarma_carril(alarma_carril)
`endif
    );

    typedef struct {
        int ocup;
        int lleno;
        int vacio;
        int led;
        int rech;
        int alarm;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    bit   done        = 0;

    // Reference model: a lane is a position along its entry or exit code path.
    int entryPath[5] = '{0, 2, 3, 1, 0};
    int exitPath[5]  = '{0, 1, 3, 2, 0};
    int laneDir[NC];
    int laneIdx[NC];
    int mOcup, pendNet, pendInv, mAlarm, age, mRech;

    // Drive one cycle of inputs and push the expected outputs after the coming edge.
    task automatic applyStimulus(input logic [NC-1:0] av, input logic [NC-1:0] bv, input logic r);
        exp_t e;
        int   code, t, newNet, newInv, nxtCode, prvCode;
        @(negedge clk);
        a   = av;
        b   = bv;
        rst = r;
        if (r) begin
            mOcup = 0; pendNet = 0; pendInv = 0; mAlarm = 0; age = 0; mRech = 0;
            for (int i = 0; i < NC; i++) begin
                laneDir[i] = 0;
                laneIdx[i] = 0;
            end
        end else begin
            age    = (mOcup == CAP) ? age + 1 : 0;
            t      = mOcup + pendNet;
            mRech  = (t < 0 || t > CAP) ? 1 : 0;
            mOcup  = (t < 0) ? 0 : ((t > CAP) ? CAP : t);
            mAlarm = mAlarm | pendInv;
            newNet = 0;
            newInv = 0;
            for (int i = 0; i < NC; i++) begin
                code = {30'd0, av[i], bv[i]};
                if (laneDir[i] == 0) begin
                    if (code == 2) begin laneDir[i] = 1; laneIdx[i] = 1; end
                    else if (code == 1) begin laneDir[i] = 2; laneIdx[i] = 1; end
                    else if (code == 3) newInv = newInv | (1 << i);
                end else begin
                    if (laneDir[i] == 1) begin
                        nxtCode = entryPath[laneIdx[i] + 1];
                        prvCode = entryPath[laneIdx[i] - 1];
                    end else begin
                        nxtCode = exitPath[laneIdx[i] + 1];
                        prvCode = exitPath[laneIdx[i] - 1];
                    end
                    if (code == ((laneDir[i] == 1) ? entryPath[laneIdx[i]] : exitPath[laneIdx[i]])) begin
                    end else if (code == nxtCode) begin
                        laneIdx[i]++;
                        if (laneIdx[i] == 4) begin
                            newNet     = newNet + ((laneDir[i] == 1) ? 1 : -1);
                            laneDir[i] = 0;
                            laneIdx[i] = 0;
                        end
                    end else if (code == prvCode) begin
                        laneIdx[i]--;
                        if (laneIdx[i] == 0) laneDir[i] = 0;
                    end else begin
                        laneDir[i] = 0;
                        laneIdx[i] = 0;
                        newInv     = newInv | (1 << i);
                    end
                end
            end
            pendNet = newNet;
            pendInv = newInv;
        end
        e.ocup  = mOcup;
        e.lleno = (mOcup == CAP) ? 1 : 0;
        e.vacio = (mOcup == 0) ? 1 : 0;
        e.led   = (mOcup == CAP && ((age / BLINK) % 2) == 1) ? 1 : 0;
        e.rech  = mRech;
        e.alarm = mAlarm;
        expQ.push_back(e);
    endtask

    task automatic drive2(input logic [1:0] c0, input logic [1:0] c1);
        applyStimulus({c1[1], c0[1]}, {c1[0], c0[0]}, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive2(2'b00, 2'b00);
    endtask

    task automatic checkField(input string name, input int act, input int req);
        testsRun++;
        if (act != req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("ocupacion", int'(ocupacion), e.ocup);
        checkField("lleno", int'(lleno), e.lleno);
        checkField("vacio", int'(vacio), e.vacio);
        checkField("led_lleno", int'(led_lleno), e.led);
        checkField("rechazo", int'(rechazo), e.rech);
`ifdef ALARMA_SECUENCIA_EN
        checkField("alarma_carril", int'(alarma_carril), e.alarm);
        checkField("alarma", int'(alarma), (e.alarm != 0) ? 1 : 0);
`endif
    endtask

    // Monitor: every DUT clock produces a full output set, popped and compared here.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] cur0, cur1;
        a   = '0;
        b   = '0;
        rst = 1'b1;
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);

        // Plan 1: lane 0 entry
        drive2(2'b00, 2'b00); drive2(2'b10, 2'b00); drive2(2'b11, 2'b00);
        drive2(2'b01, 2'b00); drive2(2'b00, 2'b00); idle(2);
        // Plan 2: second entry, lane 1 exit, lane 0 back-up then abort
        drive2(2'b10, 2'b00); drive2(2'b11, 2'b00); drive2(2'b01, 2'b00); drive2(2'b00, 2'b00); idle(2);
        drive2(2'b00, 2'b01); drive2(2'b00, 2'b11); drive2(2'b00, 2'b10); drive2(2'b00, 2'b00); idle(2);
        drive2(2'b10, 2'b00); drive2(2'b11, 2'b00); drive2(2'b10, 2'b00); drive2(2'b00, 2'b00); idle(2);
        drive2(2'b10, 2'b00); drive2(2'b11, 2'b00); drive2(2'b01, 2'b00); drive2(2'b00, 2'b00); idle(2);
        // Plan 3: simultaneous entries at 2 clamp to 3, then watch blink
        drive2(2'b10, 2'b10); drive2(2'b11, 2'b11); drive2(2'b01, 2'b01); drive2(2'b00, 2'b00);
        idle(14);
        // Plan 6: reset while lane 0 in E_AB and blinking
        drive2(2'b10, 2'b00); drive2(2'b11, 2'b00);
        applyStimulus(2'b01, 2'b01, 1'b1);
        drive2(2'b01, 2'b00); drive2(2'b00, 2'b00); idle(3);
        // Plan 4: exit and entry cancel at 0, then lone exit at 0 clamps
        drive2(2'b01, 2'b10); drive2(2'b11, 2'b11); drive2(2'b10, 2'b01); drive2(2'b00, 2'b00); idle(2);
        drive2(2'b01, 2'b00); drive2(2'b11, 2'b00); drive2(2'b10, 2'b00); drive2(2'b00, 2'b00); idle(2);
        // Plan 5: invalid jump on lane 0
        drive2(2'b00, 2'b00); drive2(2'b11, 2'b00); drive2(2'b00, 2'b00); idle(3);

        // Randomized traffic: codes tend to hold, with occasional resets
        cur0 = 2'b00;
        cur1 = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 1) == 0) cur0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) cur1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) applyStimulus({cur1[1], cur0[1]}, {cur1[0], cur0[0]}, 1'b1);
            else drive2(cur0, cur1);
        end
        idle(4);

        @(posedge clk);
        #2;
        done = 1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
